// File: rtl/cache_pkg.sv
// Shared widths and field layout for the direct-mapped data cache address path.
package cache_pkg;

  localparam int ADDR_W   = 16;
  localparam int INDEX_W  = 5;
  localparam int OFFSET_W = 5;
  localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
  localparam int WSEL_W   = OFFSET_W - 2;

  typedef struct packed {
    logic [TAG_W-1:0]   tag;
    logic [INDEX_W-1:0] index;
    logic [WSEL_W-1:0]  word_sel;
    logic [1:0]         byte_off;
  } addr_fields_t;

endpackage

// File: rtl/addr_slice.sv
// Purely combinational split of a byte address into cache fields.
module addr_slice
  import cache_pkg::*;
(
  input  logic [ADDR_W-1:0] addr,
  output addr_fields_t      fields
);

  if (OFFSET_W < 2 || TAG_W < 1) begin : gen_bad_widths
    $error("addr_slice: OFFSET_W must be >= 2 and TAG_W >= 1");
  end

  // Struct order matches address bit order, so this is a straight bit mapping.
  assign fields = addr_fields_t'(addr);

endmodule

// File: rtl/cache_address.sv
// Address-field splitter: combinational fields plus one registered stage with
// line base address and misalignment flag.
module cache_address
  import cache_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   addr,
  input  logic                addr_valid,
  output logic [TAG_W-1:0]    tag,
  output logic [INDEX_W-1:0]  index,
  output logic [WSEL_W-1:0]   word_sel,
  output logic [1:0]          byte_off,
  output logic [TAG_W-1:0]    tag_q,
  output logic [INDEX_W-1:0]  index_q,
  output logic [WSEL_W-1:0]   word_sel_q,
  output logic [1:0]          byte_off_q,
  output logic [ADDR_W-1:0]   line_addr_q,
  output logic                misaligned_q,
  output logic                out_valid
);

  addr_fields_t fields;
  addr_fields_t fields_q;
  logic         valid_q;

  addr_slice u_addr_slice (
    .addr   (addr),
    .fields (fields)
  );

  assign tag      = fields.tag;
  assign index    = fields.index;
  assign word_sel = fields.word_sel;
  assign byte_off = fields.byte_off;

  // Fields only load on a valid request so idle cycles leave the flops quiet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fields_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= addr_valid;
      if (addr_valid) begin
        fields_q <= fields;
      end
    end
  end

  assign tag_q        = fields_q.tag;
  assign index_q      = fields_q.index;
  assign word_sel_q   = fields_q.word_sel;
  assign byte_off_q   = fields_q.byte_off;
  assign line_addr_q  = {fields_q.tag, fields_q.index, {OFFSET_W{1'b0}}};
  assign misaligned_q = |fields_q.byte_off;
  assign out_valid    = valid_q;

endmodule

// File: tb/tb_cache_address.sv
// Directed bench for cache_address: combinational slices, registered stage, async reset.
module tb_cache_address;
  import cache_pkg::*;

  logic                clk;
  logic                rst_n;
  logic [ADDR_W-1:0]   addr;
  logic                addr_valid;
  logic [TAG_W-1:0]    tag;
  logic [INDEX_W-1:0]  index;
  logic [WSEL_W-1:0]   word_sel;
  logic [1:0]          byte_off;
  logic [TAG_W-1:0]    tag_q;
  logic [INDEX_W-1:0]  index_q;
  logic [WSEL_W-1:0]   word_sel_q;
  logic [1:0]          byte_off_q;
  logic [ADDR_W-1:0]   line_addr_q;
  logic                misaligned_q;
  logic                out_valid;

  int total = 0;
  int bad   = 0;

  cache_address dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .addr         (addr),
    .addr_valid   (addr_valid),
    .tag          (tag),
    .index        (index),
    .word_sel     (word_sel),
    .byte_off     (byte_off),
    .tag_q        (tag_q),
    .index_q      (index_q),
    .word_sel_q   (word_sel_q),
    .byte_off_q   (byte_off_q),
    .line_addr_q  (line_addr_q),
    .misaligned_q (misaligned_q),
    .out_valid    (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic check_comb(input logic [15:0] a, input logic [31:0] et, input logic [31:0] ei,
                            input logic [31:0] ew, input logic [31:0] eb);
    addr = a;
    #1;
    check($sformatf("tag %h", a), 32'(tag), et);
    check($sformatf("index %h", a), 32'(index), ei);
    check($sformatf("word_sel %h", a), 32'(word_sel), ew);
    check($sformatf("byte_off %h", a), 32'(byte_off), eb);
  endtask

  task automatic check_reg(input string name, input logic [31:0] ev, input logic [31:0] et,
                           input logic [31:0] ei, input logic [31:0] ew, input logic [31:0] eb,
                           input logic [31:0] el, input logic [31:0] em);
    check({name, " out_valid"}, 32'(out_valid), ev);
    check({name, " tag_q"}, 32'(tag_q), et);
    check({name, " index_q"}, 32'(index_q), ei);
    check({name, " word_sel_q"}, 32'(word_sel_q), ew);
    check({name, " byte_off_q"}, 32'(byte_off_q), eb);
    check({name, " line_addr_q"}, 32'(line_addr_q), el);
    check({name, " misaligned_q"}, 32'(misaligned_q), em);
  endtask

  initial begin
    rst_n      = 1'b0;
    addr       = 16'h0000;
    addr_valid = 1'b0;
    #3;
    check_reg("reset", 0, 0, 0, 0, 0, 0, 0);

    // Combinational slices, exercised while still in reset and without clocking.
    check_comb(16'hABCD, 32'h2A, 32'h1E, 3, 1);
    check_comb(16'h1234, 32'h04, 32'h11, 5, 0);
    check_comb(16'hFFFF, 32'h3F, 32'h1F, 7, 3);
    check_comb(16'h0000, 0, 0, 0, 0);
    check_comb(16'h5555, 32'h15, 32'h0A, 5, 1);
    addr = 16'hC3A6;
    #1;
    check("reconstruct c3a6", 32'({tag, index, word_sel, byte_off}), 32'hC3A6);
    check_reg("comb-only in reset", 0, 0, 0, 0, 0, 0, 0);

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_reg("after release idle", 0, 0, 0, 0, 0, 0, 0);

    // Single registered request then an idle edge: fields must hold.
    @(negedge clk);
    addr = 16'h5555; addr_valid = 1'b1;
    @(posedge clk); #1;
    check_reg("reg 5555", 1, 32'h15, 32'h0A, 5, 1, 32'h5540, 1);
    @(negedge clk);
    addr = 16'hFFFF; addr_valid = 1'b0;
    @(posedge clk); #1;
    check_reg("hold 5555", 0, 32'h15, 32'h0A, 5, 1, 32'h5540, 1);

    // Async reset between edges clears immediately and drops the request.
    @(negedge clk);
    addr = 16'hABCD; addr_valid = 1'b1;
    @(posedge clk); #1;
    check_reg("reg abcd", 1, 32'h2A, 32'h1E, 3, 1, 32'hABC0, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check_reg("async reset", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1; addr_valid = 1'b0;
    @(posedge clk); #1;
    check_reg("post reset idle", 0, 0, 0, 0, 0, 0, 0);

    // Back-to-back requests.
    @(negedge clk);
    addr = 16'h1234; addr_valid = 1'b1;
    @(posedge clk); #1;
    check_reg("b2b 1234", 1, 32'h04, 32'h11, 5, 0, 32'h1220, 0);
    @(negedge clk);
    addr = 16'hABCD;
    @(posedge clk); #1;
    check_reg("b2b abcd", 1, 32'h2A, 32'h1E, 3, 1, 32'hABC0, 1);
    @(negedge clk);
    addr = 16'hFFFF;
    @(posedge clk); #1;
    check_reg("reg ffff", 1, 32'h3F, 32'h1F, 7, 3, 32'hFFE0, 1);
    @(negedge clk);
    addr = 16'h0000;
    @(posedge clk); #1;
    check_reg("reg 0000", 1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    addr = 16'h1234; addr_valid = 1'b0;
    @(posedge clk); #1;
    check_reg("idle after 0000", 0, 0, 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cache_address.md
# cache_address

Address-field splitter for the direct-mapped data cache. It decomposes a byte address into tag, set index, word select and byte offset, both combinationally and through one registered pipeline stage. The stage also flags misaligned word accesses and produces the line-aligned base address. It sits between the CPU request port and the cache tag/data arrays.

## Interface
- ADDR_W, 16, byte-address width.
- INDEX_W, 5, set-index width (32 sets).
- OFFSET_W, 5, line-offset width (32-byte line = 8 words × 4 bytes); must be ≥ 2.
- Derived constant TAG_W = ADDR_W − INDEX_W − OFFSET_W (6 with defaults).
- Derived constant WSEL_W = OFFSET_W − 2 (3 with defaults).

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- addr  in  ADDR_W  request byte address.
- addr_valid  in  1  request strobe for the registered stage.
- tag  out  TAG_W  combinational, addr[ADDR_W−1 : INDEX_W+OFFSET_W].
- index  out  INDEX_W  combinational, addr[INDEX_W+OFFSET_W−1 : OFFSET_W].
- word_sel  out  WSEL_W  combinational, addr[OFFSET_W−1 : 2].
- byte_off  out  2  combinational, addr[1:0].
- tag_q, index_q, word_sel_q, byte_off_q  out  as above  registered copies.
- line_addr_q  out  ADDR_W  registered {tag, index, OFFSET_W'b0}.
- misaligned_q  out  1  registered, addr[1:0] ≠ 0.
- out_valid  out  1  registered addr_valid.

## Operation
- The combinational outputs are pure bit slices of addr, with no arithmetic. They update in the same delta as addr, independent of clk, rst_n and addr_valid.
- On a rising clk edge with addr_valid=1, all *_q outputs load the fields of the current addr, and out_valid goes to 1.
- On a rising edge with addr_valid=0:
  - out_valid goes to 0.
  - The *_q field outputs hold their previous values, to save power.
- misaligned_q is informational only. Fields are still captured when it is set.
- Field concatenation {tag, index, word_sel, byte_off} reconstructs addr exactly for all inputs.

## Timing
- Combinational path: zero-cycle latency.
- Registered path: 1-cycle latency. A request presented at edge N is visible after edge N.
- Back-to-back valids are accepted every cycle. There is no backpressure and no ready signal.
- Reset: when rst_n is asserted, all *_q outputs, line_addr_q, misaligned_q and out_valid become 0 immediately, without waiting for a clock edge.
- Reset release is synchronous to the next rising edge. The first capture happens at the first edge with rst_n=1 and addr_valid=1.
- Reset asserted mid-stream discards the in-flight request.
- Boundary behaviour:
  - addr=0x0000 gives all fields 0.
  - addr=0xFFFF gives all fields at their maximum values.
  - There is no wrap or carry logic.

## Structure
- The shared package cache_pkg holds:
  - ADDR_W, INDEX_W and OFFSET_W defaults;
  - the TAG_W and WSEL_W derivations;
  - a packed struct addr_fields_t {tag, index, word_sel, byte_off}.
- One natural sub-module is addr_slice: the purely combinational splitter, instantiated once. Its output feeds the combinational ports and the register stage.
- An elaboration-time check rejects OFFSET_W < 2 and TAG_W < 1.

## Test plan
- Combinational 0xABCD → tag 0x2A, index 0x1E, word_sel 3, byte_off 1.
- Combinational 0x1234 → tag 0x04, index 0x11, word_sel 5, byte_off 0.
- Combinational 0xFFFF → tag 0x3F, index 0x1F, word_sel 7, byte_off 3.
- Combinational 0x0000 → all fields 0.
- Combinational 0x5555 → tag 0x15, index 0x0A, word_sel 5, byte_off 1.
- Registered 0x5555 with addr_valid=1 for one edge:
  - one cycle later: out_valid=1, line_addr_q 0x5540, misaligned_q=1;
  - next edge with addr_valid=0: out_valid=0, fields hold.
- Asynchronous reset asserted between edges → all registered outputs 0 immediately.
- Back-to-back 0x1234 then 0xABCD → correct fields on consecutive cycles with out_valid held at 1.
